// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared types for the icache/dcache memory port arbiter
package mem_arb_pkg;

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;
  typedef enum logic [1:0] {OWN_NONE, OWN_IC, OWN_DC} owner_t;

endpackage

// File: rtl/mem_arb_rr_pick.sv
// rtl/mem_arb_rr_pick.sv - combinational round-robin owner selection
module mem_arb_rr_pick
  import mem_arb_pkg::*;
(
  input  logic   ic_req,
  input  logic   dc_req,
  input  owner_t last_owner,
  output owner_t pick
);

  // On a tie the requester not served last wins; anything but DC as last favours DC.
  always_comb begin
    pick = OWN_NONE;
    if (ic_req && dc_req) begin
      pick = (last_owner == OWN_DC) ? OWN_IC : OWN_DC;
    end else if (ic_req) begin
      pick = OWN_IC;
    end else if (dc_req) begin
      pick = OWN_DC;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shares the fixed-latency main memory between icache and dcache
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int MEM_LATENCY = 4,
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32
) (
  input  logic              clk,
  input  logic              rst_b,
  input  logic              ic_req,
  input  logic [ADDR_W-1:0] ic_addr,
  output logic              ic_gnt,
  output logic              ic_done,
  output logic [DATA_W-1:0] ic_rdata,
  input  logic              dc_req,
  input  logic              dc_we,
  input  logic [ADDR_W-1:0] dc_addr,
  input  logic [DATA_W-1:0] dc_wdata,
  output logic              dc_gnt,
  output logic              dc_done,
  output logic [DATA_W-1:0] dc_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  localparam int             CNT_W    = $clog2(MEM_LATENCY + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_LATENCY);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_t           state;
  owner_t           owner;
  owner_t           last_owner;
  owner_t           pick;
  logic [CNT_W-1:0] cnt;
  logic             wr_q;

  mem_arb_rr_pick u_pick (
    .ic_req     (ic_req),
    .dc_req     (dc_req),
    .last_owner (last_owner),
    .pick       (pick)
  );

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state      <= IDLE;
      owner      <= OWN_NONE;
      last_owner <= OWN_IC;
      cnt        <= '0;
      wr_q       <= 1'b0;
      ic_gnt     <= 1'b0;
      dc_gnt     <= 1'b0;
      ic_done    <= 1'b0;
      dc_done    <= 1'b0;
      mem_we     <= 1'b0;
      busy       <= 1'b0;
      ic_rdata   <= '0;
      dc_rdata   <= '0;
    end else begin
      ic_done <= 1'b0;
      dc_done <= 1'b0;
      mem_we  <= 1'b0;
      case (state)
        IDLE: begin
          if (pick != OWN_NONE) begin
            state      <= ACCESS;
            owner      <= pick;
            last_owner <= pick;
            cnt        <= CNT_ONE;
            wr_q       <= (pick == OWN_DC) && dc_we;
            ic_gnt     <= (pick == OWN_IC);
            dc_gnt     <= (pick == OWN_DC);
            busy       <= 1'b1;
            // A one-cycle memory makes the first ACCESS cycle also the write cycle.
            mem_we     <= (MEM_LATENCY == 1) && (pick == OWN_DC) && dc_we;
          end
        end
        ACCESS: begin
          if (cnt == CNT_LAST) begin
            state <= DONE;
            if (owner == OWN_IC) begin
              ic_rdata <= mem_rdata;
              ic_done  <= 1'b1;
            end else begin
              if (!wr_q) dc_rdata <= mem_rdata;
              dc_done <= 1'b1;
            end
          end else begin
            cnt    <= cnt + CNT_ONE;
            mem_we <= wr_q && (cnt == CNT_LAST - CNT_ONE);
          end
        end
        DONE: begin
          state  <= IDLE;
          owner  <= OWN_NONE;
          cnt    <= '0;
          wr_q   <= 1'b0;
          ic_gnt <= 1'b0;
          dc_gnt <= 1'b0;
          busy   <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    mem_addr  = '0;
    mem_wdata = '0;
    case (owner)
      OWN_IC: mem_addr = ic_addr;
      OWN_DC: begin
        mem_addr  = dc_addr;
        mem_wdata = dc_wdata;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - self-checking bench for mem_port_arbiter
module tb_mem_port_arbiter;

  localparam int L = 4;

  logic        clk = 1'b0;
  logic        rst_b;
  logic        ic_req, ic_gnt, ic_done, dc_req, dc_we, dc_gnt, dc_done, mem_we, busy;
  logic [31:0] ic_addr, ic_rdata, dc_addr, dc_wdata, dc_rdata, mem_addr, mem_wdata, mem_rdata;

  logic        ic_req1, ic_gnt1, ic_done1, dc_req1, dc_we1, dc_gnt1, dc_done1, mem_we1, busy1;
  logic [31:0] ic_addr1, ic_rdata1, dc_addr1, dc_wdata1, dc_rdata1, mem_addr1, mem_wdata1, mem_rdata1;

  always #5 clk = ~clk;

  mem_port_arbiter #(.MEM_LATENCY(L), .ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rst_b(rst_b),
    .ic_req(ic_req), .ic_addr(ic_addr), .ic_gnt(ic_gnt), .ic_done(ic_done), .ic_rdata(ic_rdata),
    .dc_req(dc_req), .dc_we(dc_we), .dc_addr(dc_addr), .dc_wdata(dc_wdata),
    .dc_gnt(dc_gnt), .dc_done(dc_done), .dc_rdata(dc_rdata),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_rdata(mem_rdata),
    .busy(busy)
  );

  mem_port_arbiter #(.MEM_LATENCY(1), .ADDR_W(32), .DATA_W(32)) dut1 (
    .clk(clk), .rst_b(rst_b),
    .ic_req(ic_req1), .ic_addr(ic_addr1), .ic_gnt(ic_gnt1), .ic_done(ic_done1), .ic_rdata(ic_rdata1),
    .dc_req(dc_req1), .dc_we(dc_we1), .dc_addr(dc_addr1), .dc_wdata(dc_wdata1),
    .dc_gnt(dc_gnt1), .dc_done(dc_done1), .dc_rdata(dc_rdata1),
    .mem_addr(mem_addr1), .mem_wdata(mem_wdata1), .mem_we(mem_we1), .mem_rdata(mem_rdata1),
    .busy(busy1)
  );

  int npass = 0;
  int nchk  = 0;

  // transaction-level reference: owner 0 = none, 1 = icache, 2 = dcache
  int          cyc = 0;
  int          m_owner, m_last, m_grant, m_done, m_free;
  bit          m_we, ic_act, dc_act;
  logic [31:0] m_addr, m_wdata, exp_ic_rd, exp_dc_rd;
  logic [31:0] ref_mem [logic [31:0]];
  logic [31:0] env_mem [logic [31:0]];
  int          stable, we_cnt;
  logic [31:0] last_a;
  int          order[$];

  function automatic logic [31:0] dflt(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'h0F1E2D3C;
  endfunction

  function automatic logic [31:0] ref_rd(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : dflt(a);
  endfunction

  task automatic model_clear();
    m_owner = 0; m_last = 1; m_free = 0; m_grant = 0; m_done = 0;
    ic_act = 0; dc_act = 0; ic_req = 0; dc_req = 0;
    exp_ic_rd = '0; exp_dc_rd = '0; stable = 0; last_a = '0;
  endtask

  task automatic tick(input bit new_ic, input bit new_dc, input bit nwe, input logic [31:0] a_ic,
                      input logic [31:0] a_dc, input logic [31:0] wd, input bit drop);
    bit in_acc, in_done, any;
    @(posedge clk); cyc++; #1;
    if (new_ic && !ic_act) begin ic_act = 1; ic_req = 1; ic_addr = a_ic; end
    if (new_dc && !dc_act) begin dc_act = 1; dc_req = 1; dc_we = nwe; dc_addr = a_dc; dc_wdata = wd; end
    #1;
    // environment memory: data only appears once an address has been held for L cycles
    if (busy && mem_addr == last_a) stable++; else stable = busy ? 1 : 0;
    last_a = mem_addr;
    mem_rdata = (stable == L) ? (env_mem.exists(mem_addr) ? env_mem[mem_addr] : dflt(mem_addr))
                              : (32'hBAD00000 ^ 32'(cyc));
    if (m_owner == 0 && cyc >= m_free && (ic_act || dc_act)) begin
      if (ic_act && dc_act) m_owner = (m_last == 1) ? 2 : 1;
      else                  m_owner = ic_act ? 1 : 2;
      m_last  = m_owner;
      m_grant = cyc + 1;
      m_done  = cyc + L + 1;
      m_we    = (m_owner == 2) && dc_we;
      m_addr  = (m_owner == 1) ? ic_addr : dc_addr;
      m_wdata = dc_wdata;
    end
    @(negedge clk);
    in_acc  = m_owner != 0 && cyc >= m_grant && cyc < m_done;
    in_done = m_owner != 0 && cyc == m_done;
    any     = in_acc || in_done;
    if (in_done) begin
      if (m_owner == 1) exp_ic_rd = ref_rd(m_addr);
      else if (!m_we)   exp_dc_rd = ref_rd(m_addr);
      else              ref_mem[m_addr] = m_wdata;
    end
    if (mem_we) begin env_mem[mem_addr] = mem_wdata; we_cnt++; end
    if (ic_done) order.push_back(1);
    if (dc_done) order.push_back(2);
    nchk++; if (busy !== any) $display("FAIL busy cyc=%0d got=%b exp=%b", cyc, busy, any); else npass++;
    nchk++; if (ic_gnt !== (any && m_owner == 1)) $display("FAIL ic_gnt cyc=%0d got=%b exp=%b", cyc, ic_gnt, any && m_owner == 1); else npass++;
    nchk++; if (dc_gnt !== (any && m_owner == 2)) $display("FAIL dc_gnt cyc=%0d got=%b exp=%b", cyc, dc_gnt, any && m_owner == 2); else npass++;
    nchk++; if (ic_done !== (in_done && m_owner == 1)) $display("FAIL ic_done cyc=%0d got=%b exp=%b", cyc, ic_done, in_done && m_owner == 1); else npass++;
    nchk++; if (dc_done !== (in_done && m_owner == 2)) $display("FAIL dc_done cyc=%0d got=%b exp=%b", cyc, dc_done, in_done && m_owner == 2); else npass++;
    nchk++; if (mem_we !== (in_acc && m_we && cyc == m_done - 1)) $display("FAIL mem_we cyc=%0d got=%b exp=%b", cyc, mem_we, in_acc && m_we && cyc == m_done - 1); else npass++;
    nchk++; if (ic_rdata !== exp_ic_rd) $display("FAIL ic_rdata cyc=%0d got=%h exp=%h", cyc, ic_rdata, exp_ic_rd); else npass++;
    nchk++; if (dc_rdata !== exp_dc_rd) $display("FAIL dc_rdata cyc=%0d got=%h exp=%h", cyc, dc_rdata, exp_dc_rd); else npass++;
    if (!in_done) begin
      nchk++; if (mem_addr !== (in_acc ? m_addr : 32'h0)) $display("FAIL mem_addr cyc=%0d got=%h exp=%h", cyc, mem_addr, in_acc ? m_addr : 32'h0); else npass++;
    end
    if (!any || (in_acc && m_owner == 2)) begin
      nchk++; if (mem_wdata !== (any ? m_wdata : 32'h0)) $display("FAIL mem_wdata cyc=%0d got=%h exp=%h", cyc, mem_wdata, any ? m_wdata : 32'h0); else npass++;
    end
    if (in_done) begin
      if (m_owner == 1) begin ic_req = 0; ic_act = 0; end
      else              begin dc_req = 0; dc_act = 0; end
      m_owner = 0;
      m_free  = cyc + 1;
    end else if (drop && in_acc) begin
      if (m_owner == 1) ic_req = 0; else dc_req = 0;
    end
  endtask

  task automatic idle_ticks(input int n);
    for (int i = 0; i < n; i++) tick(0, 0, 0, 32'h0, 32'h0, 32'h0, 0);
  endtask

  task automatic test_reset();
    rst_b = 0; ic_req = 0; dc_req = 0; dc_we = 0; ic_addr = 32'h1234; dc_addr = 32'h5678;
    dc_wdata = 32'h9ABC; mem_rdata = 32'hFFFF_FFFF;
    ic_req1 = 0; dc_req1 = 0; dc_we1 = 0; ic_addr1 = 0; dc_addr1 = 0; dc_wdata1 = 0; mem_rdata1 = 0;
    model_clear(); we_cnt = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    nchk++; if ({ic_gnt, dc_gnt, ic_done, dc_done, mem_we, busy} !== 6'b0) $display("FAIL reset_ctrl got=%b exp=000000", {ic_gnt, dc_gnt, ic_done, dc_done, mem_we, busy}); else npass++;
    nchk++; if (ic_rdata !== 32'h0) $display("FAIL reset_ic_rdata got=%h exp=0", ic_rdata); else npass++;
    nchk++; if (dc_rdata !== 32'h0) $display("FAIL reset_dc_rdata got=%h exp=0", dc_rdata); else npass++;
    nchk++; if (mem_addr !== 32'h0) $display("FAIL reset_mem_addr got=%h exp=0", mem_addr); else npass++;
    nchk++; if (mem_wdata !== 32'h0) $display("FAIL reset_mem_wdata got=%h exp=0", mem_wdata); else npass++;
    rst_b = 1;
  endtask

  task automatic test_ic_read();
    int we0 = we_cnt;
    env_mem[32'h40] = 32'hDEADBEEF; ref_mem[32'h40] = 32'hDEADBEEF;
    tick(1, 0, 0, 32'h40, 32'h0, 32'h0, 0);
    idle_ticks(L + 2);
    nchk++; if (ic_rdata !== 32'hDEADBEEF) $display("FAIL ic_read_data got=%h exp=deadbeef", ic_rdata); else npass++;
    nchk++; if (we_cnt !== we0) $display("FAIL ic_read_no_write got=%0d exp=%0d", we_cnt, we0); else npass++;
  endtask

  task automatic test_dc_write();
    int we0 = we_cnt;
    tick(0, 1, 1, 32'h0, 32'h100, 32'hCAFEF00D, 0);
    idle_ticks(L + 2);
    nchk++; if (we_cnt !== we0 + 1) $display("FAIL dc_write_we_count got=%0d exp=%0d", we_cnt, we0 + 1); else npass++;
    nchk++; if (env_mem[32'h100] !== 32'hCAFEF00D) $display("FAIL dc_write_mem got=%h exp=cafef00d", env_mem[32'h100]); else npass++;
    nchk++; if (dc_rdata !== 32'h0) $display("FAIL dc_write_rdata_kept got=%h exp=0", dc_rdata); else npass++;
  endtask

  task automatic test_dc_read();
    tick(0, 1, 0, 32'h0, 32'h100, 32'h0, 0);
    idle_ticks(L + 2);
    nchk++; if (dc_rdata !== 32'hCAFEF00D) $display("FAIL dc_read_data got=%h exp=cafef00d", dc_rdata); else npass++;
  endtask

  task automatic test_tie_alternate();
    rst_b = 0; #1 model_clear(); @(negedge clk); rst_b = 1;
    order.delete();
    for (int i = 0; i < 4 * (L + 2); i++) tick(1, 1, 0, 32'h200, 32'h300, 32'h0, 0);
    nchk++; if (order.size() != 4) $display("FAIL tie_count got=%0d exp=4", order.size());
    else if (order[0] != 2 || order[1] != 1 || order[2] != 2 || order[3] != 1)
      $display("FAIL tie_order got=%0d%0d%0d%0d exp=2121", order[0], order[1], order[2], order[3]);
    else npass++;
  endtask

  task automatic test_drop_midway();
    tick(0, 1, 0, 32'h0, 32'h104, 32'h0, 0);
    for (int k = 1; k <= L + 1; k++) tick(0, 0, 0, 32'h0, 32'h0, 32'h0, k == 2);
    idle_ticks(1);
  endtask

  task automatic test_reset_mid();
    tick(0, 1, 0, 32'h0, 32'h108, 32'h0, 0);
    for (int k = 1; k <= 3; k++) tick(0, 0, 0, 32'h0, 32'h0, 32'h0, 0);
    #2 rst_b = 0;
    #1;
    nchk++; if ({dc_gnt, ic_gnt, mem_we, busy, dc_done} !== 5'b0) $display("FAIL midreset_async got=%b exp=00000", {dc_gnt, ic_gnt, mem_we, busy, dc_done}); else npass++;
    model_clear();
    repeat (2) @(posedge clk);
    @(negedge clk);
    nchk++; if ({dc_done, busy} !== 2'b0) $display("FAIL midreset_no_done got=%b exp=00", {dc_done, busy}); else npass++;
    rst_b = 1;
    order.delete();
    for (int i = 0; i < 2 * (L + 2); i++) tick(1, 1, 0, 32'h210, 32'h310, 32'h0, 0);
    nchk++; if (order.size() != 2 || order[0] != 2) $display("FAIL midreset_tie got_n=%0d exp_first=2", order.size()); else npass++;
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++)
      tick($urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0, 1'($urandom_range(0, 1)),
           32'h100 + 32'($urandom_range(0, 7) << 2), 32'h100 + 32'($urandom_range(0, 7) << 2),
           $urandom, $urandom_range(0, 7) == 0);
    idle_ticks(2 * (L + 2));
    nchk++; if (busy !== 1'b0) $display("FAIL random_drain busy got=%b exp=0", busy); else npass++;
  endtask

  task automatic test_lat1();
    @(posedge clk); #1;
    dc_req1 = 1; dc_we1 = 1; dc_addr1 = 32'h20; dc_wdata1 = 32'h11223344; mem_rdata1 = 32'h55667788;
    @(negedge clk);
    nchk++; if (busy1 !== 1'b0) $display("FAIL lat1_idle got=%b exp=0", busy1); else npass++;
    @(negedge clk);
    nchk++; if ({dc_gnt1, mem_we1, busy1} !== 3'b111) $display("FAIL lat1_wr_access got=%b exp=111", {dc_gnt1, mem_we1, busy1}); else npass++;
    nchk++; if (mem_addr1 !== 32'h20 || mem_wdata1 !== 32'h11223344) $display("FAIL lat1_wr_bus got=%h/%h exp=20/11223344", mem_addr1, mem_wdata1); else npass++;
    @(negedge clk);
    nchk++; if ({dc_done1, mem_we1} !== 2'b10) $display("FAIL lat1_wr_done got=%b exp=10", {dc_done1, mem_we1}); else npass++;
    nchk++; if (dc_rdata1 !== 32'h0) $display("FAIL lat1_wr_rdata got=%h exp=0", dc_rdata1); else npass++;
    dc_req1 = 0;
    @(negedge clk);
    nchk++; if ({busy1, dc_gnt1} !== 2'b00) $display("FAIL lat1_wr_idle got=%b exp=00", {busy1, dc_gnt1}); else npass++;
    @(posedge clk); #1;
    ic_req1 = 1; ic_addr1 = 32'h24;
    @(negedge clk); @(negedge clk);
    nchk++; if ({ic_gnt1, mem_we1, mem_addr1} !== {2'b10, 32'h24}) $display("FAIL lat1_rd_access got=%b%b/%h exp=10/24", ic_gnt1, mem_we1, mem_addr1); else npass++;
    @(negedge clk);
    nchk++; if (ic_done1 !== 1'b1 || ic_rdata1 !== 32'h55667788) $display("FAIL lat1_rd_done got=%b/%h exp=1/55667788", ic_done1, ic_rdata1); else npass++;
    ic_req1 = 0;
    @(negedge clk);
    nchk++; if (busy1 !== 1'b0) $display("FAIL lat1_rd_idle got=%b exp=0", busy1); else npass++;
  endtask

  initial begin
    test_reset();
    test_ic_read();
    test_dc_write();
    test_dc_read();
    test_tie_alternate();
    test_drop_midway();
    test_reset_mid();
    test_random();
    test_lat1();
    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end

endmodule
